// File: rtl/alu_div32_if.sv
// Request/response bundle for the iterative divider: operands and start in,
// status, quotient, remainder and flags out.
interface alu_div32_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, q, r, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, q, r, div_by_zero, overflow
  );
endinterface

// File: rtl/alu_div32.sv
// Iterative restoring divider: one subtract-and-shift step per clock,
// magnitude division followed by a sign-fix cycle; registered outputs.
module alu_div32 #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  alu_div32_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_dvd, r_dvs, r_quo;
  logic             r_neg_q, r_neg_r, r_fast, r_dbz_l, r_ovf_l;
  logic             r_busy, r_done, r_dbz, r_ovf;
  logic [WIDTH-1:0] r_q, r_r;

  logic             w_accept, w_b_zero, w_ovf_case, w_last;
  logic             w_busy_d, w_done_d;
  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH:0]   w_trial;

  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_b_zero   = (bus.b == '0);
  assign w_ovf_case = bus.signed_op && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
  assign w_abs_a    = (bus.signed_op && bus.a[WIDTH-1]) ? ('0 - bus.a) : bus.a;
  assign w_abs_b    = (bus.signed_op && bus.b[WIDTH-1]) ? ('0 - bus.b) : bus.b;
  assign w_trial    = {r_rem, r_dvd[WIDTH-1]} - {1'b0, r_dvs};
  assign w_last     = (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Fast paths spend one CALC cycle without stepping so done lands two edges after start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_CALC;
      S_CALC: begin
        if (r_fast)      w_state_nxt = S_DONE;
        else if (w_last) w_state_nxt = S_FIX;
      end
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_d = (r_state == S_CALC) || (r_state == S_FIX);
    w_done_d = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_quo   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_fast  <= 1'b0;
      r_dbz_l <= 1'b0;
      r_ovf_l <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
    end else begin
      r_busy <= w_busy_d;
      r_done <= w_done_d;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt   <= '0;
            r_dvd   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_neg_q <= bus.signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r <= bus.signed_op && bus.a[WIDTH-1];
            r_fast  <= w_b_zero || w_ovf_case;
            r_dbz_l <= w_b_zero;
            r_ovf_l <= !w_b_zero && w_ovf_case;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            if (w_b_zero) begin
              r_quo <= '1;
              r_rem <= bus.a;
            end else if (w_ovf_case) begin
              r_quo <= {1'b1, {(WIDTH-1){1'b0}}};
              r_rem <= '0;
            end else begin
              r_quo <= '0;
              r_rem <= '0;
            end
          end
        end
        S_CALC: begin
          if (!r_fast) begin
            r_cnt <= r_cnt + CW'(1);
            r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
            if (!w_trial[WIDTH]) begin
              r_rem <= w_trial[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= {r_rem[WIDTH-2:0], r_dvd[WIDTH-1]};
              r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
          end
        end
        S_FIX: begin
          if (r_neg_q) r_quo <= '0 - r_quo;
          if (r_neg_r) r_rem <= '0 - r_rem;
        end
        S_DONE: begin
          r_q   <= r_quo;
          r_r   <= r_rem;
          r_dbz <= r_dbz_l;
          r_ovf <= r_ovf_l;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.q           = r_q;
  assign bus.r           = r_r;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_alu_div32.sv
// Directed self-checking bench for alu_div32: latency, busy window, results,
// fast paths, ignored start and mid-operation reset.
module tb_alu_div32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   lat, bn, seen;

  alu_div32_if #(.WIDTH(32)) bus ();
  alu_div32 #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.start = 1'b1; bus.signed_op = sgn; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom(); bus.b = $urandom();
  endtask

  task automatic wait_done(output int l, output int busy_n);
    l = 0; busy_n = 0;
    while (l < 100) begin
      @(posedge clk); #1;
      l++;
      if (bus.done) break;
      if (bus.busy) busy_n++;
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done) n++;
    end
  endtask

  task automatic run(input string tag, input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                     input int elat, input logic [31:0] eq, input logic [31:0] er,
                     input logic edbz, input logic eovf);
    int l, b;
    pulse_start(sgn, av, bv);
    wait_done(l, b);
    chk($sformatf("%s latency", tag), 32'(l), 32'(elat));
    chk($sformatf("%s busy_cycles", tag), 32'(b), 32'(elat - 1));
    chk($sformatf("%s busy_at_done", tag), 32'(bus.busy), 32'd0);
    chk($sformatf("%s q", tag), bus.q, eq);
    chk($sformatf("%s r", tag), bus.r, er);
    chk($sformatf("%s div_by_zero", tag), 32'(bus.div_by_zero), 32'(edbz));
    chk($sformatf("%s overflow", tag), 32'(bus.overflow), 32'(eovf));
    @(posedge clk); #1;
    chk($sformatf("%s done_width", tag), 32'(bus.done), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset q", bus.q, 32'd0);
    chk("reset r", bus.r, 32'd0);
    chk("reset flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
    rst = 1'b0;

    run("u100/7",     1'b0, 32'd100,       32'd7,         34, 32'd14,        32'd2,        1'b0, 1'b0);
    run("s-7/2",      1'b1, 32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run("s7/-2",      1'b1, 32'd7,         32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 32'd1,        1'b0, 1'b0);
    run("uFFFF/1",    1'b0, 32'hFFFF_FFFF, 32'd1,         34, 32'hFFFF_FFFF, 32'd0,        1'b0, 1'b0);
    run("u5/9",       1'b0, 32'd5,         32'd9,         34, 32'd0,         32'd5,        1'b0, 1'b0);
    run("u8000/FFFF", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0,         32'h8000_0000, 1'b0, 1'b0);
    run("u123/0",     1'b0, 32'h123,       32'd0,         2,  32'hFFFF_FFFF, 32'h123,      1'b0 | 1'b1, 1'b0);
    run("sovf",       1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2,  32'h8000_0000, 32'd0,        1'b0, 1'b1);
    run("s8000/0",    1'b1, 32'h8000_0000, 32'd0,         2,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
    run("s-100/-7",   1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, 32'd14,        32'hFFFF_FFFE, 1'b0, 1'b0);

    // start pulsed mid-divide must be ignored
    pulse_start(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, bn);
    chk("ignore latency", 32'(lat), 32'd24);
    chk("ignore q", bus.q, 32'd14);
    chk("ignore r", bus.r, 32'd2);
    count_done(40, seen);
    chk("ignore extra_done", 32'(seen), 32'd0);

    // reset in the middle of a divide
    pulse_start(1'b0, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst busy", 32'(bus.busy), 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    chk("midrst q", bus.q, 32'd0);
    chk("midrst r", bus.r, 32'd0);
    rst = 1'b0;
    count_done(40, seen);
    chk("midrst no_done", 32'(seen), 32'd0);
    run("u1000/10", 1'b0, 32'd1000, 32'd10, 34, 32'd100, 32'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
